// File: rtl/ahb_fifo_write.sv
`default_nettype none
// ============================================================================
// Module   : ahb_fifo_write
// Purpose  : JTAG data register that shifts host words in on TCK and pushes
//            them into the send FIFO, returning last-push status on capture.
// Revision : 1.0
// ============================================================================
module ahb_fifo_write #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  TCK,
  input  logic                  TRST,
  input  logic                  tlr_reset,
  input  logic                  dr_capture,
  input  logic                  dr_shift,
  input  logic                  dr_update,
  input  logic                  ahb_fifo_write_select,
  input  logic                  TDI,
  input  logic                  full,
  output logic                  TDO,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  winc
);

  localparam int                  c_BCNT_W   = $clog2(DATA_WIDTH + 2);
  localparam logic [c_BCNT_W-1:0] c_WORD_LEN = c_BCNT_W'(DATA_WIDTH);
  localparam logic [c_BCNT_W-1:0] c_BCNT_MAX = c_BCNT_W'(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURED = 2'd1,
    ST_SHIFTING = 2'd2,
    ST_PUSH_CHK = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_sr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [c_BCNT_W-1:0]   r_bit_cnt;
  logic [CNT_WIDTH-1:0]  r_push_cnt;
  logic                  r_ovf;
  logic                  r_len_err;
  logic                  r_winc;
  logic [DATA_WIDTH-1:0] w_status;
  logic                  w_update;
  logic                  w_accept;

  // Status word presented on the next scan after a push attempt
  always_comb begin
    w_status                  = '0;
    w_status[0]               = r_ovf;
    w_status[1]               = r_len_err;
    w_status[2]               = full;
    w_status[8 +: CNT_WIDTH]  = r_push_cnt;
  end

  // An update only counts once a capture has opened the current scan
  assign w_update = ahb_fifo_write_select && dr_update &&
                    ((r_state == ST_CAPTURED) || (r_state == ST_SHIFTING));
  assign w_accept = w_update && (r_bit_cnt == c_WORD_LEN) && !full;

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      r_state <= ST_IDLE;
    end else if (tlr_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_PUSH_CHK) begin
      w_state_nxt = ST_IDLE;
    end
    if (ahb_fifo_write_select) begin
      if (dr_capture) begin
        w_state_nxt = ST_CAPTURED;
      end else begin
        case (r_state)
          ST_CAPTURED: begin
            if (dr_shift) begin
              w_state_nxt = ST_SHIFTING;
            end else if (dr_update) begin
              w_state_nxt = ST_PUSH_CHK;
            end
          end
          ST_SHIFTING: begin
            if (dr_update) begin
              w_state_nxt = ST_PUSH_CHK;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      r_sr       <= '0;
      r_wdata    <= '0;
      r_bit_cnt  <= '0;
      r_push_cnt <= '0;
      r_ovf      <= 1'b0;
      r_len_err  <= 1'b0;
      r_winc     <= 1'b0;
    end else if (tlr_reset) begin
      r_sr       <= '0;
      r_wdata    <= '0;
      r_bit_cnt  <= '0;
      r_push_cnt <= '0;
      r_ovf      <= 1'b0;
      r_len_err  <= 1'b0;
      r_winc     <= 1'b0;
    end else begin
      r_winc <= w_accept;
      if (ahb_fifo_write_select) begin
        if (dr_capture) begin
          r_sr      <= w_status;
          r_bit_cnt <= '0;
          r_ovf     <= 1'b0;
          r_len_err <= 1'b0;
        end else if (dr_shift) begin
          r_sr <= {TDI, r_sr[DATA_WIDTH-1:1]};
          if (r_bit_cnt != c_BCNT_MAX) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end else if (w_update) begin
          if (r_bit_cnt != c_WORD_LEN) begin
            r_len_err <= 1'b1;
          end else if (full) begin
            r_ovf <= 1'b1;
          end else begin
            r_wdata    <= r_sr;
            r_push_cnt <= r_push_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign TDO   = r_sr[0];
  assign wdata = r_wdata;
  assign winc  = r_winc;

endmodule
`default_nettype wire

// File: tb/tb_ahb_fifo_write.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_fifo_write
// Purpose  : Directed scans against a scan-level model of the write-FIFO DR.
// Revision : 1.0
// ============================================================================
module tb_ahb_fifo_write;

  logic        TCK = 1'b0;
  logic        TRST = 1'b0;
  logic        tlr_reset = 1'b0;
  logic        dr_capture = 1'b0;
  logic        dr_shift = 1'b0;
  logic        dr_update = 1'b0;
  logic        sel = 1'b1;
  logic        TDI = 1'b0;
  logic        full = 1'b0;
  logic        TDO;
  logic [31:0] wdata;
  logic        winc;

  int          checks = 0;
  int          failures = 0;
  int          winc_seen = 0;
  bit          run = 1'b0;

  // Scan-level model state
  bit          m_ovf = 1'b0;
  bit          m_len = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_wdata = '0;
  bit          exp_winc = 1'b0;

  ahb_fifo_write #(.DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
    .TCK                   (TCK),
    .TRST                  (TRST),
    .tlr_reset             (tlr_reset),
    .dr_capture            (dr_capture),
    .dr_shift              (dr_shift),
    .dr_update             (dr_update),
    .ahb_fifo_write_select (sel),
    .TDI                   (TDI),
    .full                  (full),
    .TDO                   (TDO),
    .wdata                 (wdata),
    .winc                  (winc)
  );

  always #5 TCK = ~TCK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] status_word(input bit ovf, input bit len, input logic f, input int cnt);
    logic [7:0] c;
    c = 8'(cnt);
    return {16'h0, c, 5'b0, f, len, ovf};
  endfunction

  // Per-cycle compare of the FIFO write port against the model
  always @(negedge TCK) begin
    if (run && !TRST) begin
      check("winc", {31'b0, winc}, {31'b0, exp_winc});
      check("wdata", wdata, m_wdata);
      if (winc) winc_seen++;
    end
  end

  task automatic step(input bit cap, input bit sh, input bit upd, input bit tdi, output logic tdo);
    dr_capture = cap;
    dr_shift   = sh;
    dr_update  = upd;
    TDI        = tdi;
    #1;
    tdo = TDO;
    @(posedge TCK);
    #1;
    dr_capture = 1'b0;
    dr_shift   = 1'b0;
    dr_update  = 1'b0;
    exp_winc   = 1'b0;
  endtask

  // mode: 0 plain, 1 tlr_reset on the update cycle, 2 TRST during the push cycle
  task automatic scan(input logic [31:0] word, input int nbits, input bit do_upd,
                      input bit full_upd, input int pause_at, input int mode,
                      output logic [31:0] tdo_bits);
    logic [31:0] st;
    logic [31:0] mask;
    logic        t;
    tdo_bits = '0;
    st = status_word(m_ovf, m_len, full, m_cnt);
    step(1'b1, 1'b0, 1'b0, 1'b0, t);
    if (sel) begin
      m_ovf = 1'b0;
      m_len = 1'b0;
    end
    for (int i = 0; i < nbits; i++) begin
      if (i == pause_at) begin
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, t);
      end
      step(1'b0, 1'b1, 1'b0, word[i % 32], t);
      if (i < 32) tdo_bits[i] = t;
    end
    if (sel) begin
      mask = (nbits >= 32) ? 32'hFFFF_FFFF : ((32'h1 << nbits) - 32'h1);
      check("status_stream", tdo_bits & mask, st & mask);
    end
    if (do_upd) begin
      full = full_upd;
      tlr_reset = (mode == 1);
      step(1'b0, 1'b0, 1'b1, 1'b0, t);
      tlr_reset = 1'b0;
      if (mode == 1) begin
        m_ovf = 0; m_len = 0; m_cnt = 0; m_wdata = '0;
      end else if (sel) begin
        if (nbits != 32) m_len = 1'b1;
        else if (full) m_ovf = 1'b1;
        else begin
          m_wdata  = word;
          m_cnt    = (m_cnt + 1) % 256;
          exp_winc = 1'b1;
        end
      end
      if (mode == 2) begin
        #1;
        check("winc_before_trst", {31'b0, winc}, 32'h1);
        TRST = 1'b1;
        #1;
        check("trst_winc", {31'b0, winc}, 32'h0);
        check("trst_wdata", wdata, 32'h0);
        m_ovf = 0; m_len = 0; m_cnt = 0; m_wdata = '0;
        exp_winc = 1'b0;
        #1;
        TRST = 1'b0;
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, t);
  endtask

  logic [31:0] tb;

  initial begin
    #2;
    TRST = 1'b1;
    #1;
    check("rst_tdo", {31'b0, TDO}, 32'h0);
    check("rst_winc", {31'b0, winc}, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    repeat (2) @(posedge TCK);
    #1;
    TRST = 1'b0;
    run  = 1'b1;
    @(posedge TCK);
    #1;

    scan(32'h0, 32, 1'b0, 1'b0, -1, 0, tb);
    check("idle_status", tb, 32'h0000_0000);

    scan(32'hDEAD_BEEF, 32, 1'b1, 1'b0, -1, 0, tb);
    check("push_wdata", wdata, 32'hDEAD_BEEF);
    check("push_pulses", winc_seen, 1);

    scan(32'hCAFE_F00D, 31, 1'b1, 1'b0, -1, 0, tb);
    check("short_scan_status", tb & 32'h7FFF_FFFF, 32'h0000_0100);
    scan(32'h0, 32, 1'b0, 1'b0, -1, 0, tb);
    check("len_err_status", tb, 32'h0000_0102);
    scan(32'h0, 32, 1'b0, 1'b0, -1, 0, tb);
    check("len_err_cleared", tb, 32'h0000_0100);

    scan(32'h1234_5678, 32, 1'b1, 1'b1, -1, 0, tb);
    check("ovf_wdata_held", wdata, 32'hDEAD_BEEF);
    check("ovf_pulses", winc_seen, 1);
    scan(32'h0, 32, 1'b0, 1'b1, -1, 0, tb);
    check("ovf_status", tb, 32'h0000_0105);
    full = 1'b0;
    scan(32'h0, 32, 1'b0, 1'b0, -1, 0, tb);
    check("ovf_cleared", tb, 32'h0000_0100);

    scan(32'hA5C3_0F97, 32, 1'b1, 1'b0, 13, 0, tb);
    check("pause_wdata", wdata, 32'hA5C3_0F97);

    sel = 1'b0;
    scan(32'h0, 32, 1'b1, 1'b0, -1, 0, tb);
    check("deselect_tdo_held", tb, 32'hFFFF_FFFF);
    sel = 1'b1;
    check("deselect_pulses", winc_seen, 2);
    scan(32'h0, 32, 1'b0, 1'b0, -1, 0, tb);
    check("deselect_status", tb, 32'h0000_0200);

    scan(32'h0BAD_F00D, 32, 1'b1, 1'b0, -1, 1, tb);
    check("tlr_wdata", wdata, 32'h0);
    scan(32'h0, 32, 1'b0, 1'b0, -1, 0, tb);
    check("tlr_status", tb, 32'h0000_0000);

    for (int k = 0; k < 255; k++) begin
      scan(32'h1000 + k, 32, 1'b1, 1'b0, -1, 0, tb);
    end
    scan(32'h0, 32, 1'b0, 1'b0, -1, 0, tb);
    check("cnt_255_status", tb, 32'h0000_FF00);
    scan(32'h5555_AAAA, 32, 1'b1, 1'b0, -1, 0, tb);
    scan(32'h0, 32, 1'b0, 1'b0, -1, 0, tb);
    check("cnt_wrap_status", tb, 32'h0000_0000);
    check("wrap_pulses", winc_seen, 258);

    scan(32'h1357_9BDF, 32, 1'b1, 1'b0, -1, 2, tb);
    scan(32'h0, 32, 1'b0, 1'b0, -1, 0, tb);
    check("trst_status", tb, 32'h0000_0000);

    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_fifo_write.md
Name: ahb_fifo_write

Overview:
- JTAG data-register endpoint for host-to-target traffic, the write-side counterpart of the AHB read-FIFO DR.
- When its instruction is selected, it shifts a DATA_WIDTH-bit word in from TDI during Shift-DR.
- On Update-DR it pushes the word into the send asynchronous FIFO (write port clocked by TCK) for the AHB-side logic.
- On Capture-DR it loads a status word, so each scan returns the result of the previous push on TDO.

Parameters:
- DATA_WIDTH, 32: width of the shifted word and of the FIFO write data.
- CNT_WIDTH, 8: width of the accepted-push counter reported in the status word.

Ports:
- TCK  input  1  JTAG test clock; all state updates on rising edge.
- TRST  input  1  asynchronous reset, active-high.
- tlr_reset  input  1  TAP in Test-Logic-Reset; synchronous clear, same effect as TRST.
- dr_capture  input  1  TAP Capture-DR state.
- dr_shift  input  1  TAP Shift-DR state.
- dr_update  input  1  TAP Update-DR state.
- ahb_fifo_write_select  input  1  instruction decoder selects this DR.
- TDI  input  1  serial data in.
- full  input  1  send-FIFO full flag, TCK domain.
- TDO  output  1  serial data out, equal to shift register bit 0.
- wdata  output  DATA_WIDTH  FIFO write data, held stable while winc=1.
- winc  output  1  FIFO write strobe, one TCK cycle per accepted word.

Behaviour:
- Reset: TRST high asynchronously clears everything. tlr_reset=1 at a TCK edge clears everything and has priority over all other inputs. Cleared state: sr=0, TDO=0, wdata=0, winc=0, bit_cnt=0, ovf=0, len_err=0, push_cnt=0, state=IDLE.
- Gating: when ahb_fifo_write_select=0, dr_capture, dr_shift and dr_update are ignored. sr, bit_cnt and the flags hold; winc stays 0.
- State machine, evaluated on TCK rising edge:
  - IDLE: on dr_capture go to CAPTURED.
  - CAPTURED: on dr_shift go to SHIFTING.
  - SHIFTING: stays in SHIFTING while dr_shift=1; on dr_update go to PUSH_CHK. Exit1/Pause/Exit2 (all TAP enables low) hold state, sr and bit_cnt.
  - PUSH_CHK: one cycle, then IDLE. A new dr_capture in any state restarts at CAPTURED.
- Capture (selected):
  - sr loaded with the status word: sr[0]=ovf, sr[1]=len_err, sr[2]=full, sr[7:3]=0, sr[8+CNT_WIDTH-1:8]=push_cnt, all higher bits 0.
  - bit_cnt cleared; ovf and len_err cleared in the same cycle (read-to-clear).
- Shift (selected):
  - sr shifts right LSB-first: sr <= {TDI, sr[DATA_WIDTH-1:1]}.
  - bit_cnt increments and saturates at DATA_WIDTH+1.
  - TDO is combinational from sr[0], so the first status bit is valid during the first Shift-DR cycle.
- Update (selected), evaluated on the dr_update cycle:
  - If bit_cnt != DATA_WIDTH: set len_err; no push.
  - Else if full=1: set ovf; no push; FIFO untouched.
  - Else: wdata <= sr and winc=1 for exactly the next TCK cycle (PUSH_CHK state); push_cnt increments, wrapping at 2^CNT_WIDTH.
  - Update without a preceding capture in the current scan (state IDLE) produces no push and no flag change.
- wdata holds its last pushed value until the next push or reset.
- ovf and len_err are sticky until the next capture or reset.
- full is sampled only on the dr_update cycle. A full transition during the winc cycle does not cancel the push; the FIFO protects itself.
- Reset mid-operation: TRST or tlr_reset during PUSH_CHK forces winc low immediately (TRST) or at that edge (tlr_reset). No partial word is ever pushed.
- Capture and update are mutually exclusive TAP states, so flag set and flag clear never coincide.

Test Plan:
- Reset/idle: TRST=1 then 0 -> TDO=0, winc=0, wdata=0. Capture then 32 shifts -> TDO stream is all zeros (status 0x00000000).
- Normal push: capture, shift 0xDEADBEEF LSB-first (32 bits), update with full=0 -> winc=1 for one cycle with wdata=0xDEADBEEF. Next scan's TDO status = 0x00000100 (push_cnt=1).
- Length error: shift 31 bits, update -> no winc. Next capture status bit1=1 (0x00000002). The following capture after that shows bit1=0.
- Overflow: full=1 on update after a valid 32-bit shift of 0x12345678 -> no winc, wdata unchanged. Next status = 0x00000005 if full is still 1 (ovf plus full bit).
- Deselect/pause: ahb_fifo_write_select=0 during 32 shifts and update -> no winc, sr unchanged. With select=1, inserting a Pause-DR mid-word still pushes the correct 32-bit word.
- Reset priority: tlr_reset asserted in the same cycle as dr_update of a valid word -> no winc, all state cleared. push_cnt wrap: 256 valid pushes -> push_cnt=0.
